icc_branch_unit: RTL and testbench

- Integer condition-code (icc) stage directly downstream of mini_alu in the SPARC datapath.
- Captures the ALU's 4-bit flags into the icc register on cc-setting instructions and feeds the carry back to the ALU `cin` for ADDX/SUBX.
- Evaluates the 16 Bicc branch conditions against icc.
- Runs the delayed-branch / annul state machine that tells the pipeline whether to squash the delay-slot instruction.

---
 rtl/icc_branch_unit.sv | 106 ++++++++++
 tb/tb_icc_branch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/icc_branch_unit.sv
// icc_branch_unit: integer condition-code register, Bicc condition
// evaluation and delayed-branch / annul state machine.
// Optional feature macro: ICC_BYPASS_EN. When it is defined, a Bicc
// evaluates against the flags being written in the same cycle. When it
// is undefined, a Bicc evaluates only against the registered icc.
module icc_branch_unit #(
  parameter logic [3:0] ICC_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] alu_flags,
  input  logic       cc_write,
  input  logic       stall,
  input  logic       is_bicc,
  input  logic [3:0] cond,
  input  logic       annul_bit,
  output logic [3:0] icc,
  output logic       alu_cin,
  output logic       branch_taken,
  output logic       annul,
  output logic       in_delay_slot
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    ANNUL = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] icc_q, icc_d;
  logic [3:0] eff;
  logic       cond_base;
  logic       cond_true;
  logic       annul_req;

  // Flags used for branch evaluation: optionally bypass the flags being written.
`ifdef ICC_BYPASS_EN
  assign eff = cc_write ? alu_flags : icc_q;
`else
  assign eff = icc_q;
`endif

  // Next icc: capture the ALU flags on an unstalled cc-setting op.
  always_comb begin
    // NOTE: assign a default first so that no path through the block leaves
    // the signal unassigned, which would otherwise infer a latch.
    icc_d = icc_q;
    if (cc_write && !stall) icc_d = alu_flags;
  end

  // Evaluate the Bicc condition; cond[3] inverts the base test in cond[2:0].
  always_comb begin
    cond_base = 1'b0;
    unique case (cond[2:0])
      3'b000: cond_base = 1'b0;                         // never / always
      3'b001: cond_base = eff[2];                       // Z
      3'b010: cond_base = eff[2] | (eff[3] ^ eff[1]);   // Z | (N ^ V)
      3'b011: cond_base = eff[3] ^ eff[1];              // N ^ V
      3'b100: cond_base = eff[0] | eff[2];              // C | Z
      3'b101: cond_base = eff[0];                       // C
      3'b110: cond_base = eff[3];                       // N
      3'b111: cond_base = eff[1];                       // V
      default: cond_base = 1'b0;
    endcase
    cond_true = cond_base ^ cond[3];
    // Branch-always with a=1 annuls the delay slot. Any untaken branch with
    // a=1 annuls it as well. A taken conditional branch never annuls it.
    annul_req = annul_bit & ((cond == 4'b1000) | !cond_true);
  end

  // Next FSM state: transitions advance only when the pipeline is not stalled.
  always_comb begin
    state_d = state_q;
    if (!stall) begin
      unique case (state_q)
        IDLE, DELAY: begin
          if (is_bicc)    state_d = annul_req ? ANNUL : DELAY;
          else            state_d = IDLE;
        end
        ANNUL:            state_d = IDLE;
        default:          state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      icc_q   <= ICC_RESET;
      state_q <= IDLE;
    end else begin
      icc_q   <= icc_d;
      state_q <= state_d;
    end
  end

  assign icc           = icc_q;
  assign alu_cin       = icc_q[0];
  assign branch_taken  = is_bicc & cond_true & (state_q != ANNUL);
  assign annul         = (state_q == ANNUL);
  assign in_delay_slot = (state_q != IDLE);

endmodule

// File: tb/tb_icc_branch_unit.sv
// Self-checking bench for icc_branch_unit: table-driven condition sweep and
// annul matrix, plus directed stall, reset and bypass sequences.
module tb_icc_branch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] alu_flags;
  logic       cc_write;
  logic       stall;
  logic       is_bicc;
  logic [3:0] cond;
  logic       annul_bit;
  logic [3:0] icc;
  logic       alu_cin;
  logic       branch_taken;
  logic       annul;
  logic       in_delay_slot;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] cond;
    logic       exp_taken;
  } cond_vec_t;

  typedef struct packed {
    logic [3:0] cond;
    logic       annul_bit;
    logic       exp_taken;
    logic       exp_annul;
    logic       exp_ds;
  } annul_vec_t;

  cond_vec_t  cond_tbl[16];
  annul_vec_t annul_tbl[5];
  logic [15:0] taken_mask;
  logic        exp_bypass;

  icc_branch_unit #(.ICC_RESET(4'b0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_flags     (alu_flags),
    .cc_write      (cc_write),
    .stall         (stall),
    .is_bicc       (is_bicc),
    .cond          (cond),
    .annul_bit     (annul_bit),
    .icc           (icc),
    .alu_cin       (alu_cin),
    .branch_taken  (branch_taken),
    .annul         (annul),
    .in_delay_slot (in_delay_slot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; alu_flags = 4'b0000; cc_write = 1'b0; stall = 1'b0;
    is_bicc = 1'b0; cond = 4'b0000; annul_bit = 1'b0;
  endtask

  task automatic load_icc(input logic [3:0] f);
    idle_inputs();
    alu_flags = f; cc_write = 1'b1;
    tick();
    idle_inputs();
  endtask

  initial begin
    // icc = 1010 (N=1, Z=0, V=1, C=0): taken for cond 6..13.
    taken_mask = 16'h3FC0;
    for (int i = 0; i < 16; i++) begin
      cond_tbl[i].cond      = 4'(i);
      cond_tbl[i].exp_taken = taken_mask[i];
    end
    // icc = 0100 (Z=1).                   cond    a     tkn   ann   ds
    annul_tbl[0] = '{cond: 4'b0001, annul_bit: 1'b1, exp_taken: 1'b1, exp_annul: 1'b0, exp_ds: 1'b1}; // BE,a
    annul_tbl[1] = '{cond: 4'b1001, annul_bit: 1'b1, exp_taken: 1'b0, exp_annul: 1'b1, exp_ds: 1'b1}; // BNE,a
    annul_tbl[2] = '{cond: 4'b1000, annul_bit: 1'b1, exp_taken: 1'b1, exp_annul: 1'b1, exp_ds: 1'b1}; // BA,a
    annul_tbl[3] = '{cond: 4'b1001, annul_bit: 1'b0, exp_taken: 1'b0, exp_annul: 1'b0, exp_ds: 1'b1}; // BNE
    annul_tbl[4] = '{cond: 4'b0000, annul_bit: 1'b1, exp_taken: 1'b0, exp_annul: 1'b1, exp_ds: 1'b1}; // BN,a
`ifdef ICC_BYPASS_EN
    exp_bypass = 1'b1;
`else
    exp_bypass = 1'b0;
`endif

    // Reset and icc capture.
    idle_inputs();
    reset = 1'b1; alu_flags = 4'b1111; cc_write = 1'b1;
    tick();
    check("reset_icc", icc, 4'b0000);
    check("reset_annul", {3'b0, annul}, 4'b0);
    check("reset_ds", {3'b0, in_delay_slot}, 4'b0);
    load_icc(4'b1101);
    check("capture_icc", icc, 4'b1101);
    check("capture_cin", {3'b0, alu_cin}, 4'b1);
    alu_flags = 4'b0000;
    tick();
    check("hold_icc", icc, 4'b1101);

    // Condition sweep with annul_bit=0, so the FSM never enters ANNUL.
    load_icc(4'b1010);
    check("sweep_icc", icc, 4'b1010);
    for (int i = 0; i < 16; i++) begin
      is_bicc = 1'b1; cond = cond_tbl[i].cond;
      #1;
      check($sformatf("cond_%0d_taken", i), {3'b0, branch_taken}, {3'b0, cond_tbl[i].exp_taken});
      tick();
    end
    idle_inputs();
    tick();
    check("sweep_end_ds", {3'b0, in_delay_slot}, 4'b0);

    // Annul matrix, starting from IDLE each time.
    load_icc(4'b0100);
    for (int i = 0; i < 5; i++) begin
      is_bicc = 1'b1; cond = annul_tbl[i].cond; annul_bit = annul_tbl[i].annul_bit;
      #1;
      check($sformatf("annul_%0d_taken", i), {3'b0, branch_taken}, {3'b0, annul_tbl[i].exp_taken});
      tick();
      idle_inputs();
      check($sformatf("annul_%0d_annul", i), {3'b0, annul}, {3'b0, annul_tbl[i].exp_annul});
      check($sformatf("annul_%0d_ds", i), {3'b0, in_delay_slot}, {3'b0, annul_tbl[i].exp_ds});
      tick();
      check($sformatf("annul_%0d_idle", i), {3'b0, in_delay_slot | annul}, 4'b0);
    end

    // DCTI couple: a Bicc in the delay slot is evaluated as from IDLE.
    is_bicc = 1'b1; cond = 4'b0001; annul_bit = 1'b0;   // BE, taken -> DELAY
    tick();
    cond = 4'b1000; annul_bit = 1'b1;                   // BA,a in delay slot
    #1;
    check("dcti_taken", {3'b0, branch_taken}, 4'b1);
    tick();
    idle_inputs();
    check("dcti_annul", {3'b0, annul}, 4'b1);
    tick();
    check("dcti_idle", {3'b0, in_delay_slot}, 4'b0);

    // Stall while in ANNUL: state and icc freeze, Bicc ignored.
    is_bicc = 1'b1; cond = 4'b1000; annul_bit = 1'b1;
    tick();
    stall = 1'b1; cc_write = 1'b1; alu_flags = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_%0d_taken", i), {3'b0, branch_taken}, 4'b0);
      tick();
      check($sformatf("stall_%0d_annul", i), {3'b0, annul}, 4'b1);
      check($sformatf("stall_%0d_icc", i), icc, 4'b0100);
      check($sformatf("stall_%0d_cin", i), {3'b0, alu_cin}, 4'b0);
    end
    idle_inputs();
    tick();
    check("stall_release_annul", {3'b0, annul}, 4'b0);
    check("stall_release_ds", {3'b0, in_delay_slot}, 4'b0);

    // Reset while in ANNUL overrides cc_write and stall.
    is_bicc = 1'b1; cond = 4'b1000; annul_bit = 1'b1;
    tick();
    check("pre_reset_annul", {3'b0, annul}, 4'b1);
    idle_inputs();
    reset = 1'b1; cc_write = 1'b1; alu_flags = 4'b1111; stall = 1'b1;
    tick();
    idle_inputs();
    check("mid_reset_icc", icc, 4'b0000);
    check("mid_reset_annul", {3'b0, annul}, 4'b0);
    check("mid_reset_ds", {3'b0, in_delay_slot}, 4'b0);

    // Same-cycle cc_write and Bicc (BE); only the bypass build sees Z=1.
    cc_write = 1'b1; alu_flags = 4'b0100; is_bicc = 1'b1; cond = 4'b0001;
    #1;
    check("bypass_taken", {3'b0, branch_taken}, {3'b0, exp_bypass});
    tick();
    idle_inputs();
    check("bypass_icc", icc, 4'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
